// File: rtl/multicycle_control_fsm.sv
// Multicycle MIPS-style main control unit: a Moore FSM whose datapath controls
// are decoded from the current state. In FETCH, IRWrite/PCWrite are
// additionally qualified by MemReady.
//
// Ports:
//   clk, rst_n        clock (rising edge) and async active-low reset
//   Op                instruction opcode field (OP_W bits)
//   MemReady          memory access completes this cycle
//   PCWrite .. ALUSrcA  single-bit datapath controls
//   PCSource, ALUSrcB, ALUOp  2-bit mux selects / ALU control class
//   State             current state code (debug)
//   IllegalOp         one-cycle pulse in DECODE on an undecodable opcode
//
// Parameters:
//   OP_W      opcode width (5..8)
//   WAIT_MEM  1: memory states stall on MemReady; 0: MemReady treated as 1
//   EN_BNE    1: bne (0x05) decoded; 0: 0x05 is illegal
module multicycle_control_fsm #(
  parameter int unsigned OP_W     = 6,
  parameter int unsigned WAIT_MEM = 1,
  parameter int unsigned EN_BNE   = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [OP_W-1:0] Op,
  input  logic            MemReady,
  output logic            PCWrite,
  output logic            PCWriteCond,
  output logic            PCWriteCondNe,
  output logic            IorD,
  output logic            MemRead,
  output logic            MemWrite,
  output logic            IRWrite,
  output logic            MemtoReg,
  output logic            RegWrite,
  output logic            RegDst,
  output logic            ALUSrcA,
  output logic [1:0]      PCSource,
  output logic [1:0]      ALUSrcB,
  output logic [1:0]      ALUOp,
  output logic [3:0]      State,
  output logic            IllegalOp
);

  localparam int unsigned ST_W = 4;

  typedef enum logic [ST_W-1:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11
  } state_t;

  localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(8'h00);
  localparam logic [OP_W-1:0] OP_LW    = OP_W'(8'h23);
  localparam logic [OP_W-1:0] OP_SW    = OP_W'(8'h2B);
  localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(8'h04);
  localparam logic [OP_W-1:0] OP_BNE   = OP_W'(8'h05);
  localparam logic [OP_W-1:0] OP_J     = OP_W'(8'h02);
  localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(8'h08);

  localparam logic BNE_ON = (EN_BNE != 0);

  state_t          r_state;
  state_t          w_next;
  logic [OP_W-1:0] r_op;
  logic            w_mem_rdy;

  // With WAIT_MEM=0 memory is assumed single-cycle
  assign w_mem_rdy = (WAIT_MEM != 0) ? MemReady : 1'b1;

  assign State = r_state;

  // State and latched-opcode registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
      r_op    <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) begin
        r_op <= Op;
      end
    end
  end

  // Next-state and control decode; everything is held at 0 while in reset so
  // an asserted reset cancels any in-flight register/memory/PC write at once.
  always_comb begin
    w_next        = r_state;
    PCWrite       = 1'b0;
    PCWriteCond   = 1'b0;
    PCWriteCondNe = 1'b0;
    IorD          = 1'b0;
    MemRead       = 1'b0;
    MemWrite      = 1'b0;
    IRWrite       = 1'b0;
    MemtoReg      = 1'b0;
    RegWrite      = 1'b0;
    RegDst        = 1'b0;
    ALUSrcA       = 1'b0;
    PCSource      = 2'b00;
    ALUSrcB       = 2'b00;
    ALUOp         = 2'b00;
    IllegalOp     = 1'b0;

    if (rst_n) begin
      case (r_state)
        S_FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = 2'b01;
          IRWrite = w_mem_rdy;
          PCWrite = w_mem_rdy;
          if (w_mem_rdy) begin
            w_next = S_DECODE;
          end
        end
        S_DECODE: begin
          ALUSrcB = 2'b11;
          // Decode uses the live opcode; later states use the latched copy
          if ((Op == OP_LW) || (Op == OP_SW)) begin
            w_next = S_MEMADR;
          end else if (Op == OP_RTYPE) begin
            w_next = S_EXEC;
          end else if ((Op == OP_BEQ) || (BNE_ON && (Op == OP_BNE))) begin
            w_next = S_BRANCH;
          end else if (Op == OP_J) begin
            w_next = S_JUMP;
          end else if (Op == OP_ADDI) begin
            w_next = S_ADDIEX;
          end else begin
            w_next    = S_FETCH;
            IllegalOp = 1'b1;
          end
        end
        S_MEMADR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
          w_next  = (r_op == OP_LW) ? S_MEMRD : S_MEMWR;
        end
        S_MEMRD: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
          if (w_mem_rdy) begin
            w_next = S_MEMWB;
          end
        end
        S_MEMWB: begin
          MemtoReg = 1'b1;
          RegWrite = 1'b1;
          w_next   = S_FETCH;
        end
        S_MEMWR: begin
          MemWrite = 1'b1;
          IorD     = 1'b1;
          if (w_mem_rdy) begin
            w_next = S_FETCH;
          end
        end
        S_EXEC: begin
          ALUSrcA = 1'b1;
          ALUOp   = 2'b10;
          w_next  = S_ALUWB;
        end
        S_ALUWB: begin
          RegDst   = 1'b1;
          RegWrite = 1'b1;
          w_next   = S_FETCH;
        end
        S_BRANCH: begin
          ALUSrcA       = 1'b1;
          ALUOp         = 2'b01;
          PCSource      = 2'b01;
          // Opcodes are distinct, so at most one of these can assert
          PCWriteCond   = (r_op == OP_BEQ);
          PCWriteCondNe = BNE_ON && (r_op == OP_BNE);
          w_next        = S_FETCH;
        end
        S_JUMP: begin
          PCWrite  = 1'b1;
          PCSource = 2'b10;
          w_next   = S_FETCH;
        end
        S_ADDIEX: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
          w_next  = S_ADDIWB;
        end
        S_ADDIWB: begin
          RegWrite = 1'b1;
          w_next   = S_FETCH;
        end
        default: begin
          w_next = S_FETCH;
        end
      endcase
    end
  end

endmodule

// File: doc/multicycle_control_fsm.md
MULTICYCLE_CONTROL_FSM -- requirements
Module: multicycle_control_fsm

Interface
REQ-001 Parameter OP_W, default 6, opcode field width (valid range 5..8).
REQ-002 Parameter WAIT_MEM, default 1: when 1, memory states stall on MemReady; when 0, MemReady is ignored and treated as 1.
REQ-003 Parameter EN_BNE, default 1: when 1, bne (opcode 0x05) is decoded; when 0, 0x05 is illegal.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 Op  input  OP_W  opcode field of the instruction register.
REQ-007 MemReady  input  1  memory access completes this cycle.
REQ-008 PCWrite, PCWriteCond, PCWriteCondNe, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegWrite, RegDst, ALUSrcA  output  1 each  datapath controls.
REQ-009 PCSource, ALUSrcB, ALUOp  output  2 each  datapath mux selects and ALU control class.
REQ-010 State  output  4  current state encoding, for debug.
REQ-011 IllegalOp  output  1  one-cycle pulse on an undecodable opcode.

Function
REQ-012 Moore FSM; all outputs SHALL be combinational decodes of State, except the MemReady qualification in REQ-015; outputs not listed for a state SHALL be 0.
REQ-013 State encodings SHALL be: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11. Codes 12..15 SHALL transition to FETCH.
REQ-014 Opcodes, zero-extended to OP_W: R-type 0x00, lw 0x23, sw 0x2B, beq 0x04, bne 0x05, j 0x02, addi 0x08.
REQ-015 FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00. IRWrite=PCWrite=MemReady. Go to DECODE only when MemReady=1; otherwise hold.
REQ-016 DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00. Latch Op into an internal register. Next state: lw/sw->MEMADR, R-type->EXEC, beq/bne->BRANCH, j->JUMP, addi->ADDIEX. Any other opcode->FETCH with IllegalOp=1 for this cycle.
REQ-017 MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next state MEMRD for lw, MEMWR for sw, selected by the latched opcode.
REQ-018 MEMRD: MemRead=1, IorD=1. Go to MEMWB on MemReady; otherwise hold.
REQ-019 MEMWB: RegDst=0, MemtoReg=1, RegWrite=1. Next state FETCH.
REQ-020 MEMWR: MemWrite=1, IorD=1. Go to FETCH on MemReady; otherwise hold with MemWrite held at 1.
REQ-021 EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next state ALUWB.
REQ-022 ALUWB: RegDst=1, MemtoReg=0, RegWrite=1. Next state FETCH.
REQ-023 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSource=01. Assert PCWriteCond for beq or PCWriteCondNe for bne (latched opcode), never both. Next state FETCH.
REQ-024 JUMP: PCWrite=1, PCSource=10. Next state FETCH.
REQ-025 ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next state ADDIWB.
REQ-026 ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1. Next state FETCH.
REQ-027 Cycle counts with no stalls: R-type/addi 4, lw 5, sw 4, beq/bne 3, j 3; each MemReady=0 cycle in FETCH/MEMRD/MEMWR adds exactly one cycle.
REQ-028 Op changes outside DECODE SHALL NOT affect state sequencing.
REQ-029 MemRead and MemWrite SHALL never be 1 in the same cycle; RegWrite and any PC write SHALL never be 1 in the same cycle.

Reset
REQ-030 While rst_n=0: State=FETCH, the latched opcode is 0, and every control output is forced to 0, including IRWrite and PCWrite.
REQ-031 Reset assertion mid-instruction SHALL abort that instruction immediately, asynchronously, with no partial register or memory write after the assertion.
REQ-032 After rst_n rises, the first rising clk edge SHALL evaluate FETCH normally.

Verification
REQ-033 Reset release, MemReady=1, Op=0x00 -> State sequence 0,1,6,7,0; RegWrite=1 and RegDst=1 only in state 7.
REQ-034 Op=0x23 with MemReady low for 2 cycles in MEMRD -> sequence 0,1,2,3,3,3,4,0; MemtoReg=1 in state 4.
REQ-035 Op=0x05, EN_BNE=1 -> 0,1,8,0 with PCWriteCondNe=1 and PCWriteCond=0 in state 8. Repeat with EN_BNE=0 -> 0,1,0 with IllegalOp pulsed in state 1.
REQ-036 Op=0x2B, MemReady=0 in FETCH for 3 cycles -> IRWrite=PCWrite=0 in those cycles, then 1 in the ready cycle; MemWrite=1 only in state 5.
REQ-037 rst_n driven low asynchronously during MEMWR -> MemWrite drops to 0 before the next edge and State=0.
REQ-038 Op=0x3F and Op=0x02 -> IllegalOp pulse then FETCH; j gives 0,1,9,0 with PCSource=10.
